// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one registered adder between NREQ valid/ready requesters.
// One operation in flight: IDLE (grant) -> ISSUE -> CAPT -> RESP (tagged response).
module adder_rr_sched #(
  parameter int WIDTH = 40,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next, id_reg, grant;
  logic [IDW:0]     idx, ptr_inc;
  logic             any_valid;
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
      assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign any_valid = |req_valid;

  // Walk from the farthest candidate back to ptr so the last hit is the first in rotating order.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (req_valid[idx[IDW-1:0]]) grant = idx[IDW-1:0];
    end
  end

  always_comb begin
    ptr_inc  = {1'b0, grant} + 1'b1;
    ptr_next = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          req_ready[grant] = 1'b1;
          state_next       = ISSUE;
        end
      end
      ISSUE:   state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg   <= '0;
      id_reg    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            add_a   <= op_a[grant];
            add_b   <= op_b[grant];
            id_reg  <= grant;
            ptr_reg <= ptr_next;
          end
        end
        CAPT: begin
          rsp_data  <= add_c;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched; models the shared registered adder locally.
module tb_adder_rr_sched;
  localparam int WIDTH = 40;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_c;
  logic                  rsp_valid, rsp_ready, busy;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;

  int vectors    = 0;
  int miscompares = 0;

  adder_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered adder with the shared async reset
  always @(posedge clk or negedge rst) begin
    if (!rst) add_c <= '0;
    else      add_c <= add_a + add_b;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, busy, req_ready} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: valid/busy/ready=%b required 000000", {rsp_valid, busy, req_ready});
    end
    vectors++;
    if ({rsp_data, rsp_id, add_a, add_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: data=%0d id=%0d a=%0d b=%0d required all 0", rsp_data, rsp_id, add_a, add_b);
    end
    $display("reset: checked cleared outputs");
  endtask

  task automatic test_round_robin;
    logic [IDW-1:0] exp;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(i);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(100);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp = IDW'(n % NREQ);
      @(negedge clk);
      vectors++;
      if (req_ready !== NREQ'(1 << exp)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: req_ready=%b required %b", n, req_ready, NREQ'(1 << exp));
      end
      @(posedge clk); #1; @(negedge clk);
      vectors++;
      if ({req_ready, rsp_valid, add_a, add_b} !== {4'b0, 1'b0, WIDTH'(exp), WIDTH'(100)}) begin
        miscompares++;
        $display("FAIL rr_issue%0d: ready=%b valid=%b a=%0d b=%0d required 0000 0 %0d 100", n, req_ready, rsp_valid, add_a, add_b, exp);
      end
      @(posedge clk); #1; @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_capt%0d: rsp_valid=%b required 0", n, rsp_valid);
      end
      @(posedge clk); #1; @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(100 + int'(exp)), exp}) begin
        miscompares++;
        $display("FAIL rr_rsp%0d: valid=%b data=%0d id=%0d required 1 %0d %0d", n, rsp_valid, rsp_data, rsp_id, 100 + int'(exp), exp);
      end
      $display("round_robin: op %0d grant %0d data %0d id %0d", n, exp, rsp_data, rsp_id);
      @(posedge clk); #1;
      if (n == 4) req_valid = '0;
    end
  endtask

  task automatic test_fairness;
    logic [IDW-1:0] exp;
    req_valid = 4'b1001;
    for (int n = 0; n < 2; n++) begin
      exp = (n == 0) ? IDW'(3) : IDW'(0);
      @(negedge clk);
      vectors++;
      if (req_ready !== NREQ'(1 << exp)) begin
        miscompares++;
        $display("FAIL fair_grant%0d: req_ready=%b required %b", n, req_ready, NREQ'(1 << exp));
      end
      @(posedge clk); #1; @(negedge clk);
      @(posedge clk); #1; @(negedge clk);
      @(posedge clk); #1; @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(100 + int'(exp)), exp}) begin
        miscompares++;
        $display("FAIL fair_rsp%0d: valid=%b data=%0d id=%0d required 1 %0d %0d", n, rsp_valid, rsp_data, rsp_id, 100 + int'(exp), exp);
      end
      $display("fairness: op %0d grant %0d data %0d", n, exp, rsp_data);
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_single;
    req_a[1*WIDTH +: WIDTH] = WIDTH'(5);
    req_b[1*WIDTH +: WIDTH] = WIDTH'(7);
    req_valid = 4'b0010;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_grant: req_ready=%b required 0010", req_ready);
    end
    @(posedge clk); #1; req_valid = '0; @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, add_a, add_b} !== {1'b1, 1'b0, WIDTH'(5), WIDTH'(7)}) begin
      miscompares++;
      $display("FAIL single_issue: busy=%b valid=%b a=%0d b=%0d required 1 0 5 7", busy, rsp_valid, add_a, add_b);
    end
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_capt: rsp_valid=%b required 0", rsp_valid);
    end
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(12), IDW'(1)}) begin
      miscompares++;
      $display("FAIL single_rsp: valid=%b data=%0d id=%0d required 1 12 1", rsp_valid, rsp_data, rsp_id);
    end
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({rsp_valid, busy, req_ready} !== 6'b0) begin
      miscompares++;
      $display("FAIL single_idle: valid/busy/ready=%b required 000000", {rsp_valid, busy, req_ready});
    end
    $display("single: data %0d id %0d", 12, 1);
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    logic [WIDTH-1:0] maxv;
    maxv = '1;
    req_a[0 +: WIDTH] = maxv;
    req_b[0 +: WIDTH] = WIDTH'(2);
    req_valid = 4'b0001;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_grant: req_ready=%b required 0001", req_ready);
    end
    @(posedge clk); #1; req_valid = '0; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(1), IDW'(0)}) begin
      miscompares++;
      $display("FAIL wrap_rsp: valid=%b data=%0d id=%0d required 1 1 0", rsp_valid, rsp_data, rsp_id);
    end
    $display("wrap: data %0d id %0d", rsp_data, rsp_id);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    req_a[3*WIDTH +: WIDTH] = WIDTH'(10);
    req_b[3*WIDTH +: WIDTH] = WIDTH'(20);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_grant: req_ready=%b required 1000", req_ready);
    end
    @(posedge clk); #1;
    req_a[1*WIDTH +: WIDTH] = WIDTH'(3);
    req_b[1*WIDTH +: WIDTH] = WIDTH'(4);
    req_valid = 4'b0010;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0) begin
        miscompares++;
        $display("FAIL bp_ready%0d: req_ready=%b required 0000", c, req_ready);
      end
      if (c >= 2) begin
        vectors++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(30), IDW'(3)}) begin
          miscompares++;
          $display("FAIL bp_hold%0d: valid=%b data=%0d id=%0d required 1 30 3", c, rsp_valid, rsp_data, rsp_id);
        end
      end
      @(posedge clk); #1;
      if (c == 11) rsp_ready = 1'b1;
    end
    $display("backpressure: held data 30 id 3 for 11 cycles");
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid} !== {4'b0010, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_next_grant: ready=%b valid=%b required 0010 0", req_ready, rsp_valid);
    end
    @(posedge clk); #1; req_valid = '0; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(7), IDW'(1)}) begin
      miscompares++;
      $display("FAIL bp_rsp2: valid=%b data=%0d id=%0d required 1 7 1", rsp_valid, rsp_data, rsp_id);
    end
    $display("backpressure: follow-up data %0d id %0d", rsp_data, rsp_id);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    req_a[1*WIDTH +: WIDTH] = WIDTH'(9);
    req_b[1*WIDTH +: WIDTH] = WIDTH'(9);
    req_valid = 4'b0010;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL rm_grant: req_ready=%b required 0010", req_ready);
    end
    @(posedge clk); #1; req_valid = '0; @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_busy_issue: busy=%b required 1", busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, rsp_valid, req_ready, add_a} !== {1'b0, 1'b0, 4'b0, WIDTH'(0)}) begin
      miscompares++;
      $display("FAIL rm_cleared: busy=%b valid=%b ready=%b a=%0d required 0 0 0000 0", busy, rsp_valid, req_ready, add_a);
    end
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; @(negedge clk);
      vectors++;
      if ({rsp_valid, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL rm_no_rsp%0d: valid=%b busy=%b required 0 0", c, rsp_valid, busy);
      end
    end
    @(posedge clk); #1;
    req_a[0 +: WIDTH] = WIDTH'(4);
    req_b[0 +: WIDTH] = WIDTH'(4);
    req_a[2*WIDTH +: WIDTH] = WIDTH'(1);
    req_b[2*WIDTH +: WIDTH] = WIDTH'(1);
    req_valid = 4'b0101;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rm_ptr_zero: req_ready=%b required 0001", req_ready);
    end
    @(posedge clk); #1; req_valid = 4'b0100; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(8), IDW'(0)}) begin
      miscompares++;
      $display("FAIL rm_rsp0: valid=%b data=%0d id=%0d required 1 8 0", rsp_valid, rsp_data, rsp_id);
    end
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL rm_grant2: req_ready=%b required 0100", req_ready);
    end
    @(posedge clk); #1; req_valid = '0; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, WIDTH'(2), IDW'(2)}) begin
      miscompares++;
      $display("FAIL rm_rsp2: valid=%b data=%0d id=%0d required 1 2 2", rsp_valid, rsp_data, rsp_id);
    end
    $display("reset_midop: post-reset data %0d id %0d", rsp_data, rsp_id);
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    test_round_robin;
    test_fairness;
    test_single;
    test_wrap;
    test_backpressure;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Round-robin scheduler that shares one registered WIDTH-bit adder (dut_top, 1-cycle latency) between NREQ requesters.
- Each requester uses a valid/ready request channel.
- Results return on a single valid/ready response channel, tagged with the requester index.
- Sits between the requester ports and one dut_top instance; the scheduler drives dut_top's operand inputs and captures its result.

Parameters:
- WIDTH, 40, operand/result width; must match the adder instance.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the response tag.

Ports:
- clk  in  1  single clock; also clocks the adder.
- rst  in  1  asynchronous, active-low reset; shared with the adder.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  flattened operand A; slice i = [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  flattened operand B, same slicing.
- add_a  out  WIDTH  registered operand A to the adder.
- add_b  out  WIDTH  registered operand B to the adder.
- add_c  in  WIDTH  adder registered result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  WIDTH  sum.
- rsp_id  out  IDW  index of the requester that produced rsp_data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async) clears all of the following:
  - state=IDLE, ptr=0.
  - add_a, add_b, rsp_data, rsp_id = 0.
  - rsp_valid=0, busy=0, req_ready=0.
- FSM states, one operation outstanding at a time:
  - IDLE: if any req_valid, grant g = first set bit searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
    - req_ready[g]=1 combinationally in this cycle only.
    - At the edge: add_a<=req_a[g], add_b<=req_b[g], id<=g, ptr<=(g+1) mod NREQ, state->ISSUE.
    - If no req_valid: stay in IDLE, req_ready=0.
  - ISSUE: operands stable; the adder registers the sum at this edge; state->CAPT.
  - CAPT: add_c is valid; at the edge rsp_data<=add_c, rsp_id<=id, rsp_valid<=1, state->RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_id are held stable.
    - On rsp_valid&&rsp_ready: rsp_valid<=0 at the edge, state->IDLE.
    - No new grant is issued in the RESP cycle itself.
- Latency: accept edge to rsp_valid high = 3 cycles. Minimum issue interval = 4 cycles when rsp_ready is held high.
- req_ready outside IDLE is always 0. Requests are never dropped; requesters hold valid until they are accepted.
- Arithmetic: result is modulo 2^WIDTH and the carry is discarded, matching the adder.
- ptr advances only on a grant. A lone requester is granted repeatedly.
- Simultaneous rsp_ready with the RESP entry edge has no effect; acceptance counts only while rsp_valid=1.
- Reset mid-operation:
  - The in-flight operation is discarded and no response is issued.
  - Any requester whose request was accepted but not answered must re-request.
  - The adder output is also cleared by the shared reset.
- add_a/add_b hold their last value outside ISSUE; do not check them except in ISSUE.

Test Plan:
- Single request: req_valid=4'b0010, a=5, b=7 -> req_ready=4'b0010 for one cycle; rsp_valid 3 cycles after accept; rsp_data=12, rsp_id=1.
- All four valid continuously (a=i, b=100), rsp_ready=1 -> grants in order 0,1,2,3,0; responses 100,101,102,103,100 with matching ids; 4-cycle spacing.
- Wrap: a=2^40-1, b=2 -> rsp_data=1, no other effect.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout. Raise rsp_ready -> next grant in the cycle after the handshake.
- Fairness: after a grant to 0, req_valid=4'b1001 -> grant 3, then 0.
- Reset mid-op: pull rst low during ISSUE for 1 cycle -> rsp_valid=0, busy=0, no response. Then request from 2 with a=1, b=1 -> grant 2 (ptr back at 0), rsp_data=2.
